bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 24 ++
 rtl/bcd_add3.sv | 13 +
 rtl/bin2bcd_seq.sv | 139 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    // Converter control states: wait for start, run the shift loop, present the result.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } bin2bcd_state_e;

    // Nibble shown on every digit when the value does not fit (blanks a 7-seg decoder).
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // 10^n, used to derive the largest value representable in n BCD digits.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the left shift
// so that the shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Pure combinational correction of one nibble.
    always_comb begin
        digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One bit is consumed per clock, so a
// conversion occupies WIDTH shift cycles followed by a single DONE cycle carrying the result.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned CntW    = $clog2(WIDTH + 1);
    localparam int unsigned BcdW    = 4 * DIGITS;
    localparam int unsigned CatW    = BcdW + WIDTH;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    // Largest value that fits in DIGITS decimal digits.
    localparam logic [63:0] BcdMax  = 64'(pow10(DIGITS) - 1);

    bin2bcd_state_e    state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [BcdW-1:0]   scratch_q, scratch_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_lat_q, ovf_lat_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BcdW-1:0]   scratch_adj;
    logic [CatW-1:0]   shift_cat;
    logic              bin_ovf;

    // Per-digit +3 correction applied to the current scratch register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (scratch_adj[4*g +: 4])
        );
    end

    // Corrected scratch and remaining binary bits shifted left as one long register.
    always_comb begin
        shift_cat = {scratch_adj, sr_q} << 1;
    end

    // Range check on the raw input; zero-extension keeps the compare unsigned.
    always_comb begin
        bin_ovf = (64'(bin) > BcdMax);
    end

    // Next-state and datapath control; outputs are decoded from the next state so they are
    // registered yet line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovf_lat_d = ovf_lat_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sr_d      = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    ovf_lat_d = bin_ovf;
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = shift_cat[CatW-1 -: BcdW];
                sr_d      = shift_cat[WIDTH-1:0];
                cnt_d     = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // Last bit shifted in: publish so the result is visible during DONE.
                    state_d = StDone;
                    bcd_d   = ovf_lat_q ? {DIGITS{BCD_BLANK}} : shift_cat[CatW-1 -: BcdW];
                    ovf_d   = ovf_lat_q;
                end
            end
            StDone: begin
                // Start is deliberately ignored here; a new request is taken in IDLE.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StIdle);
        busy_d  = (state_d == StShift);
        done_d  = (state_d == StDone);
    end

    // All state and registered outputs; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_lat_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_lat_q <= ovf_lat_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq; expected values come from decimal arithmetic.
module tb_bin2bcd_seq;

    localparam int unsigned W = 14;
    localparam int unsigned D = 4;
    localparam int          LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  bin;
    logic          ready;
    logic          busy;
    logic          done;
    logic [4*D-1:0] bcd;
    logic          ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    // Reference: decimal digits by division, all-F when the value needs more than D digits.
    function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
        logic [4*D-1:0] r;
        int unsigned    x;
        int unsigned    lim;
        lim = 1;
        for (int i = 0; i < int'(D); i++) lim = lim * 10;
        if (v >= lim) return {D{4'hF}};
        r = '0;
        x = v;
        for (int i = 0; i < int'(D); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v);
        return v > 9999;
    endfunction

    // Pulse start for one cycle; lat is the 1-based cycle after the accepting edge in which
    // done is seen (capped at 40 if it never comes).
    task automatic run_conv(input logic [W-1:0] v, output int lat);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({ready, busy, done, ovf} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_flags: got rdy/busy/done/ovf=%b want 1000",
                     {ready, busy, done, ovf});
        end
        tests++;
        if (bcd !== 16'h0000) begin
            fails++;
            $display("FAIL reset_bcd: got %h want 0000", bcd);
        end
        rst = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bin   = 14'd123;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        tests++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_over_start: got ready=%b busy=%b want 1 0", ready, busy);
        end
    endtask

    task automatic test_zero();
        int cyc;
        int flag_bad;
        @(negedge clk);
        bin   = '0;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        flag_bad = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1 || ready !== 1'b0) flag_bad++;
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (cyc != LAT) begin
            fails++;
            $display("FAIL zero_latency: got %0d want %0d", cyc, LAT);
        end
        tests++;
        if (flag_bad != 0) begin
            fails++;
            $display("FAIL zero_busy_flags: got %0d bad cycles want 0", flag_bad);
        end
        tests++;
        if (bcd !== 16'h0000 || ovf !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL zero_result: got bcd=%h ovf=%b busy=%b ready=%b want 0000 0 0 0",
                     bcd, ovf, busy, ready);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL done_pulse_width: got done=%b ready=%b want 0 1", done, ready);
        end
    endtask

    task automatic test_known();
        logic [W-1:0] vals [4];
        int lat;
        vals = '{14'd1234, 14'd9999, 14'd10000, 14'd5};
        for (int i = 0; i < 4; i++) begin
            run_conv(vals[i], lat);
            tests++;
            if (lat != LAT || bcd !== ref_bcd(vals[i]) || ovf !== ref_ovf(vals[i])) begin
                fails++;
                $display("FAIL known_%0d: got lat=%0d bcd=%h ovf=%b want %0d %h %b",
                         vals[i], lat, bcd, ovf, LAT, ref_bcd(vals[i]), ref_ovf(vals[i]));
            end
        end
    endtask

    task automatic test_start_held();
        int ndone;
        int n;
        logic [4*D-1:0] first_bcd;
        @(negedge clk);
        bin   = 14'd42;
        start = 1'b1;
        @(negedge clk);
        ndone     = 0;
        first_bcd = 'x;
        for (int cyc = 1; cyc <= LAT; cyc++) begin
            if (cyc == 5) bin = 14'd7;
            if (done === 1'b1) begin
                ndone++;
                first_bcd = bcd;
            end
            @(negedge clk);
        end
        tests++;
        if (ndone != 1 || first_bcd !== 16'h0042) begin
            fails++;
            $display("FAIL held_first: got dones=%0d bcd=%h want 1 0042", ndone, first_bcd);
        end
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || bcd !== 16'h0007 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL held_second: got done=%b bcd=%h ovf=%b want 1 0007 0", done, bcd, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic [4*D-1:0] held;
        int lat;
        int bad;
        run_conv(14'd8051, lat);
        held = ref_bcd(8051);
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bin = 14'($urandom_range(0, 16383));
            if (bcd !== held || ovf !== 1'b0 || done !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_outputs: got %0d changed cycles want 0 (held %h)", bad, held);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int ndone;
        run_conv(14'd1234, lat);
        @(negedge clk);
        bin   = 14'd3456;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        // Now in SHIFT cycle 6.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({ready, busy, done, ovf} !== 4'b1000 || bcd !== 16'h0000) begin
            fails++;
            $display("FAIL reset_mid: got rdy/busy/done/ovf=%b bcd=%h want 1000 0000",
                     {ready, busy, done, ovf}, bcd);
        end
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        tests++;
        if (ndone != 0 || bcd !== 16'h0000) begin
            fails++;
            $display("FAIL reset_mid_no_done: got dones=%0d bcd=%h want 0 0000", ndone, bcd);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_conv(14'd777, lat);
        run_conv(14'd3081, lat);
        tests++;
        if (lat != LAT || bcd !== 16'h3081) begin
            fails++;
            $display("FAIL back_to_back: got lat=%0d bcd=%h want %0d 3081", lat, bcd, LAT);
        end
    endtask

    task automatic test_random();
        int unsigned v;
        int lat;
        logic nib_bad;
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 16383);
            run_conv(14'(v), lat);
            tests++;
            if (lat != LAT || bcd !== ref_bcd(v) || ovf !== ref_ovf(v)) begin
                fails++;
                $display("FAIL random_%0d: got lat=%0d bcd=%h ovf=%b want %0d %h %b",
                         v, lat, bcd, ovf, LAT, ref_bcd(v), ref_ovf(v));
            end
            nib_bad = 1'b0;
            for (int k = 0; k < int'(D); k++) begin
                if (bcd[4*k +: 4] > 4'd9) nib_bad = 1'b1;
            end
            if (ovf === 1'b0) begin
                tests++;
                if (nib_bad !== 1'b0) begin
                    fails++;
                    $display("FAIL random_nibble_%0d: got bcd=%h want all nibbles <= 9", v, bcd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_known();
        test_start_held();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
